row_stream_mdl: RTL
===================

Name: row_stream_mdl

Overview:
Matrix-to-row serializer; the transmit-side counterpart of the matrix row buffer. Captures one full matrix of COLUMN_SIZE rows (each ROW_SIZE elements of DATA_SIZE bits) in a single parallel load. Streams it out one row per accepted handshake, row 0 first, and flags the last row with dendFlag. Sits between a matrix_mdl result and a row-serial consumer, such as another row buffer or an output link.

Parameters:
DATA_SIZE, 16, bits per element
COLUMN_SIZE, 16, rows per matrix (>=2)
ROW_SIZE, 16, elements per row

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
enable  input  1  global advance enable; low freezes all state and outputs
dsetFlag  input  1  load strobe: datsIn holds a valid full matrix
datsIn  input  DATA_SIZE*COLUMN_SIZE*ROW_SIZE  matrix; row r = datsIn[r*DATA_SIZE*ROW_SIZE +: DATA_SIZE*ROW_SIZE]
loadReady  output  1  high when a load will be accepted (state IDLE)
dats  output  DATA_SIZE*ROW_SIZE  current row, registered
dvalid  output  1  dats is valid
dready  input  1  consumer accepts dats this cycle
dendFlag  output  1  high with dvalid while the last row (r = COLUMN_SIZE-1) is presented

Behaviour:
- Reset (async, reset=0): state=IDLE, row index=0, matrix register=0, dats=0, dvalid=0, dendFlag=0. loadReady is 1 once reset is released.
- Row index width is $clog2(COLUMN_SIZE). It never exceeds COLUMN_SIZE-1.
- loadReady = (state==IDLE). It is combinational from state only and does not depend on enable.
- State IDLE:
  - Condition enable=1 and dsetFlag=1: capture datsIn into the matrix register. Set dats<=row0, dvalid<=1, dendFlag<=0, index<=0, go to SEND.
  - Load-to-first-row latency is 1 cycle: dvalid rises on the edge that captures the load.
  - dsetFlag without enable: ignored.
- State SEND:
  - Handshake = enable & dvalid & dready.
  - No handshake: dats, dvalid, dendFlag and index hold; dats stays stable while dvalid=1.
  - Handshake with index<COLUMN_SIZE-1: index<=index+1 and dats<=row[index+1]. dendFlag<=1 if index+1==COLUMN_SIZE-1, else 0.
  - Handshake with index==COLUMN_SIZE-1: dvalid<=0, dendFlag<=0, dats<=0, index<=0, go to IDLE.
- A matrix takes exactly COLUMN_SIZE handshakes. With dready held high, rows appear on consecutive cycles.
- dsetFlag in SEND (loadReady=0) is ignored, with no effect on the stream in flight. This includes the cycle of the final handshake: that load is dropped, and the producer must hold dsetFlag until loadReady=1.
- Minimum matrix-to-matrix gap: final handshake, then one IDLE cycle for the load, then row0 valid.
- enable=0 in any state: no state, index, register or output changes, even if dready=1 or dsetFlag=1.
- Reset mid-stream: immediate return to reset values; the partial matrix is discarded. The next load starts at row 0.
- Captured matrix register is not cleared after the stream. It is overwritten only by the next accepted load.

Test Plan:
(All scenarios use DATA_SIZE=4, ROW_SIZE=2, COLUMN_SIZE=3, so rows are 8 bits.)
- Basic stream: load datsIn=24'hCCBBAA with dready=1 -> dats=AA,BB,CC on 3 consecutive cycles with dvalid=1. dendFlag=1 only with CC. dvalid=0 and loadReady=1 on the next cycle.
- Backpressure: dready=0 for 4 cycles after row0 -> dats stays AA with dvalid=1 and index unchanged. Releasing dready resumes BB, CC; exactly 3 handshakes total.
- Enable freeze: enable=0 mid-stream with dready=1 for 3 cycles -> no advance and dats holds. dsetFlag=1 in IDLE with enable=0 -> loadReady stays 1 and dvalid stays 0.
- Load during SEND: pulse dsetFlag with datsIn=24'h332211 while streaming CCBBAA, including on the final-handshake cycle -> output is still AA,BB,CC. A hold-until-loadReady load then yields 11,22,33.
- Async reset: assert reset between clock edges while dats=BB -> dvalid, dendFlag and dats are 0 immediately. After release, loadReady=1 and a new load starts at row0.
- Back-to-back: dsetFlag held high continuously with 24'hCCBBAA -> pattern AA,BB,CC, one idle cycle (dvalid=0), then AA repeats.

Source files
------------

// File: rtl/row_stream_mdl.sv
// Matrix-to-row serializer: parallel-loads one matrix and streams it out row by row
// over a valid/ready handshake, flagging the final row with dendFlag.
module row_stream_mdl #(
    parameter int DATA_SIZE   = 16,
    parameter int COLUMN_SIZE = 16,
    parameter int ROW_SIZE    = 16
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       enable,
    input  logic                                       dsetFlag,
    input  logic [DATA_SIZE*COLUMN_SIZE*ROW_SIZE-1:0]  datsIn,
    output logic                                       loadReady,
    output logic [DATA_SIZE*ROW_SIZE-1:0]              dats,
    output logic                                       dvalid,
    input  logic                                       dready,
    output logic                                       dendFlag
);

    localparam int ROW_W = DATA_SIZE * ROW_SIZE;
    localparam int IDX_W = (COLUMN_SIZE > 1) ? $clog2(COLUMN_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COLUMN_SIZE - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next, idx_inc;
    logic [ROW_W-1:0]   dats_reg, dats_next;
    logic               dvalid_reg, dvalid_next;
    logic               dend_reg, dend_next;
    logic               load_en;
    logic [ROW_W-1:0]   load_rows  [COLUMN_SIZE];
    logic [ROW_W-1:0]   matrix_reg [COLUMN_SIZE];

    // Each row of the captured matrix is its own register, loaded only on an accepted load.
    genvar gi;
    generate
        for (gi = 0; gi < COLUMN_SIZE; gi++) begin : g_rows
            assign load_rows[gi] = datsIn[gi*ROW_W +: ROW_W];

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    matrix_reg[gi] <= '0;
                end else if (load_en) begin
                    matrix_reg[gi] <= load_rows[gi];
                end
            end
        end
    endgenerate

    assign idx_inc = idx_reg + IDX_W'(1);

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        dats_next   = dats_reg;
        dvalid_next = dvalid_reg;
        dend_next   = dend_reg;
        load_en     = 1'b0;
        if (enable) begin
            case (state_reg)
                IDLE: begin
                    if (dsetFlag) begin
                        // Row 0 bypasses the matrix register so it is valid on the capture edge.
                        load_en     = 1'b1;
                        dats_next   = load_rows[0];
                        dvalid_next = 1'b1;
                        dend_next   = 1'b0;
                        idx_next    = '0;
                        state_next  = SEND;
                    end
                end
                SEND: begin
                    if (dvalid_reg && dready) begin
                        if (idx_reg == LAST_IDX) begin
                            dats_next   = '0;
                            dvalid_next = 1'b0;
                            dend_next   = 1'b0;
                            idx_next    = '0;
                            state_next  = IDLE;
                        end else begin
                            idx_next    = idx_inc;
                            dats_next   = matrix_reg[idx_inc];
                            dend_next   = (idx_inc == LAST_IDX);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            dats_reg   <= '0;
            dvalid_reg <= 1'b0;
            dend_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            dats_reg   <= dats_next;
            dvalid_reg <= dvalid_next;
            dend_reg   <= dend_next;
        end
    end

    assign loadReady = (state_reg == IDLE);
    assign dats      = dats_reg;
    assign dvalid    = dvalid_reg;
    assign dendFlag  = dend_reg;

endmodule
